// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data memory arbiter: FSM encoding, access size
// codes (must match data_memory), address segment bases, and the bundled
// request type the arbiter muxes onto the memory port.
package mem_arb_pkg;

  // Arbiter FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Access size codes understood by data_memory
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Upper-halfword segment bases of the address map
  localparam logic [15:0] SEG_DATA   = 16'h1000;
  localparam logic [15:0] SEG_STACK  = 16'h7fff;
  localparam logic [15:0] SEG_SERIAL = 16'hffff;

  // One requester's access as presented to the memory port
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
  } mem_req_t;

endpackage

// File: rtl/data_mem_arbiter_rr_select.sv
// Purpose : two-input round-robin picker; on a tie the requester that was
//           not granted last wins.
// Latency : purely combinational. Backpressure: none, caller samples result.
// Ports   : req0/req1 request levels, last = previously granted requester,
//           grant_vld = some request present, winner = chosen requester.
module rr_select (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_vld,
  output logic winner
);

  assign grant_vld = req0 | req1;
  // Lone request wins outright; a tie goes to the one not served last.
  assign winner    = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/data_mem_arbiter.sv
// Purpose : shares the single data_memory request port between the CPU
//           load/store unit (r0) and the serial loader / debug DMA (r1).
// Latency : request seen in IDLE at edge N, memory driven in N+1, ack in N+2;
//           3 cycles per access unlocked, 2 cycles per access while locked.
// Backpressure: requesters hold req and access fields stable until ack;
//           the losing requester simply waits with req held.
// Ports   : clock/reset; per requester req/lock/addr/wdata/we/size in and
//           ack/rdata out; mem_* drive data_memory, mem_readdata_in returns
//           its combinational read data.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        r0_req_in,
  input  logic        r0_lock_in,
  input  logic [31:0] r0_addr_in,
  input  logic [31:0] r0_wdata_in,
  input  logic        r0_we_in,
  input  logic [1:0]  r0_size_in,
  output logic        r0_ack_out,
  output logic [31:0] r0_rdata_out,

  input  logic        r1_req_in,
  input  logic        r1_lock_in,
  input  logic [31:0] r1_addr_in,
  input  logic [31:0] r1_wdata_in,
  input  logic        r1_we_in,
  input  logic [1:0]  r1_size_in,
  output logic        r1_ack_out,
  output logic [31:0] r1_rdata_out,

  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_writedata_out,
  output logic        mem_re_out,
  output logic        mem_we_out,
  output logic [1:0]  mem_size_out,
  input  logic [31:0] mem_readdata_in
);

  localparam int              CW         = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0]   LOCK_LIMIT = CW'(LOCK_MAX);

  logic [1:0]    state;
  logic          owner;
  logic          last;
  logic [CW-1:0] lock_cnt;
  logic [31:0]   rdata;

  logic          grant_vld;
  logic          winner;

  mem_req_t      r0_acc;
  mem_req_t      r1_acc;
  mem_req_t      cur;
  logic          owner_req;
  logic          owner_lock;
  logic          busy;
  logic          ack_phase;

  assign r0_acc     = '{r0_addr_in, r0_wdata_in, r0_we_in, r0_size_in};
  assign r1_acc     = '{r1_addr_in, r1_wdata_in, r1_we_in, r1_size_in};
  assign cur        = owner ? r1_acc : r0_acc;
  assign owner_req  = owner ? r1_req_in  : r0_req_in;
  assign owner_lock = owner ? r1_lock_in : r0_lock_in;

  rr_select u_rr_select (
    .req0      (r0_req_in),
    .req1      (r1_req_in),
    .last      (last),
    .grant_vld (grant_vld),
    .winner    (winner)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;   // requester 0 takes the first tie
      lock_cnt <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            owner    <= winner;
            lock_cnt <= CW'(1);
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          rdata <= cur.we ? 32'h0 : mem_readdata_in;
          last  <= owner;
          state <= ST_ACK;
        end
        ST_ACK: begin
          // A locked owner has already presented its next access, so go
          // straight back to BUSY until the lock budget runs out. Since
          // last == owner by now, a waiting peer wins the following IDLE.
          if (owner_req && owner_lock && (lock_cnt < LOCK_LIMIT)) begin
            lock_cnt <= lock_cnt + CW'(1);
            state    <= ST_BUSY;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory port is driven only in BUSY; reset forces IDLE, clearing it at once.
  assign busy              = (state == ST_BUSY);
  assign mem_addr_out      = busy ? cur.addr  : 32'h0;
  assign mem_writedata_out = busy ? cur.wdata : 32'h0;
  assign mem_re_out        = busy & ~cur.we;
  assign mem_we_out        = busy &  cur.we;
  assign mem_size_out      = busy ? cur.size  : 2'b00;

  assign ack_phase    = (state == ST_ACK);
  assign r0_ack_out   = ack_phase & ~owner;
  assign r1_ack_out   = ack_phase &  owner;
  assign r0_rdata_out = r0_ack_out ? rdata : 32'h0;
  assign r1_rdata_out = r1_ack_out ? rdata : 32'h0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: reset, write/read, tie round-robin,
// bounded lock, reset mid-access and a serial-segment read.
// Inputs driven and outputs checked on the falling clock edge.
module tb_data_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        r0_req_in = 0, r0_lock_in = 0, r0_we_in = 0;
  logic [31:0] r0_addr_in = 0, r0_wdata_in = 0;
  logic [1:0]  r0_size_in = 0;
  logic        r0_ack_out;
  logic [31:0] r0_rdata_out;

  logic        r1_req_in = 0, r1_lock_in = 0, r1_we_in = 0;
  logic [31:0] r1_addr_in = 0, r1_wdata_in = 0;
  logic [1:0]  r1_size_in = 0;
  logic        r1_ack_out;
  logic [31:0] r1_rdata_out;

  logic [31:0] mem_addr_out, mem_writedata_out, mem_readdata_in;
  logic        mem_re_out, mem_we_out;
  logic [1:0]  mem_size_out;

  int checks = 0;
  int errors = 0;

  // Memory model: 16 words selected by addr[5:2], preset to C0DE_000i.
  logic [31:0] mem_model [16];
  int          we_cnt = 0, re_cnt = 0, both_cnt = 0, r1_ack_cnt = 0;

  localparam logic [31:0] A_DATA   = 32'h1000_0010;
  localparam logic [31:0] A_STACK  = 32'h7fff_fffc;
  localparam logic [31:0] A_SER    = 32'hffff_0000;
  localparam logic [31:0] A_SER4   = 32'hffff_0004;

  data_mem_arbiter #(.LOCK_MAX(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .r0_req_in         (r0_req_in),
    .r0_lock_in        (r0_lock_in),
    .r0_addr_in        (r0_addr_in),
    .r0_wdata_in       (r0_wdata_in),
    .r0_we_in          (r0_we_in),
    .r0_size_in        (r0_size_in),
    .r0_ack_out        (r0_ack_out),
    .r0_rdata_out      (r0_rdata_out),
    .r1_req_in         (r1_req_in),
    .r1_lock_in        (r1_lock_in),
    .r1_addr_in        (r1_addr_in),
    .r1_wdata_in       (r1_wdata_in),
    .r1_we_in          (r1_we_in),
    .r1_size_in        (r1_size_in),
    .r1_ack_out        (r1_ack_out),
    .r1_rdata_out      (r1_rdata_out),
    .mem_addr_out      (mem_addr_out),
    .mem_writedata_out (mem_writedata_out),
    .mem_re_out        (mem_re_out),
    .mem_we_out        (mem_we_out),
    .mem_size_out      (mem_size_out),
    .mem_readdata_in   (mem_readdata_in)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 16; i++) mem_model[i] = 32'hC0DE_0000 + i;
  end

  assign mem_readdata_in = mem_model[mem_addr_out[5:2]];

  always @(posedge clock) begin
    if (mem_we_out) mem_model[mem_addr_out[5:2]] <= mem_writedata_out;
  end

  always @(negedge clock) begin
    if (mem_we_out) we_cnt++;
    if (mem_re_out) re_cnt++;
    if (mem_we_out && mem_re_out) both_cnt++;
    if (r1_ack_out) r1_ack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic logic any_out();
    return |{r0_ack_out, r0_rdata_out, r1_ack_out, r1_rdata_out, mem_addr_out,
             mem_writedata_out, mem_re_out, mem_we_out, mem_size_out};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    r0_req_in = 0; r0_lock_in = 0; r1_req_in = 0; r1_lock_in = 0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // {re, r1_ack, r0_ack} per cycle for the lock scenario
  logic [2:0] t4_exp [1:17];
  int we_base, re_base, ack_base;

  initial begin
    t4_exp = '{3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b001,
               3'b000, 3'b100, 3'b010, 3'b000, 3'b100, 3'b001, 3'b100, 3'b001,
               3'b000};

    // ---- reset: 3 cycles held, everything quiet
    tick();
    do_reset();
    check("reset_outputs_zero", {31'b0, any_out()}, 32'h0);

    // ---- r0 word write then read-back
    r0_addr_in = A_DATA; r0_wdata_in = 32'hDEAD_BEEF; r0_we_in = 1; r0_size_in = SIZE_WORD;
    we_base = we_cnt;
    r0_req_in = 1;
    tick();
    check("wr_busy_we",   {31'b0, mem_we_out}, 32'h1);
    check("wr_busy_re",   {31'b0, mem_re_out}, 32'h0);
    check("wr_busy_addr", mem_addr_out, A_DATA);
    check("wr_busy_data", mem_writedata_out, 32'hDEAD_BEEF);
    check("wr_busy_size", {30'b0, mem_size_out}, {30'b0, SIZE_WORD});
    check("wr_busy_noack", {31'b0, r0_ack_out}, 32'h0);
    tick();
    check("wr_ack",       {31'b0, r0_ack_out}, 32'h1);
    check("wr_ack_rdata", r0_rdata_out, 32'h0);
    check("wr_ack_mem_idle", {31'b0, mem_we_out}, 32'h0);
    r0_req_in = 0;
    tick();
    check("wr_ack_single", {31'b0, r0_ack_out}, 32'h0);
    check("wr_we_cycles", we_cnt - we_base, 32'd1);

    r0_we_in = 0; r0_req_in = 1;
    tick();
    check("rd_busy_re", {31'b0, mem_re_out}, 32'h1);
    tick();
    check("rd_ack",       {31'b0, r0_ack_out}, 32'h1);
    check("rd_ack_rdata", r0_rdata_out, 32'hDEAD_BEEF);
    r0_req_in = 0;
    tick();

    // ---- ties: r0 first after reset, then r1 after an r0 access
    do_reset();
    r0_addr_in = A_DATA; r0_we_in = 0;
    r1_addr_in = A_SER4; r1_we_in = 0; r1_size_in = SIZE_WORD;
    r0_req_in = 1; r1_req_in = 1;
    tick();
    check("tie1_first_addr", mem_addr_out, A_DATA);
    tick();
    check("tie1_r0_ack", {30'b0, r1_ack_out, r0_ack_out}, 32'h1);
    r0_req_in = 0;
    tick();
    check("tie1_idle", {31'b0, mem_re_out}, 32'h0);
    tick();
    check("tie1_second_addr", mem_addr_out, A_SER4);
    tick();
    check("tie1_r1_ack", {30'b0, r1_ack_out, r0_ack_out}, 32'h2);
    check("tie1_r1_rdata", r1_rdata_out, 32'hC0DE_0001);
    r1_req_in = 0;
    tick();
    r0_req_in = 1;
    tick(); tick();
    check("solo_r0_ack", {30'b0, r1_ack_out, r0_ack_out}, 32'h1);
    r0_req_in = 0;
    tick();
    r0_req_in = 1; r1_req_in = 1;
    tick();
    check("tie2_first_addr", mem_addr_out, A_SER4);
    tick();
    check("tie2_r1_ack", {30'b0, r1_ack_out, r0_ack_out}, 32'h2);
    r1_req_in = 0;
    tick(); tick();
    check("tie2_second_addr", mem_addr_out, A_DATA);
    tick();
    check("tie2_r0_ack", {30'b0, r1_ack_out, r0_ack_out}, 32'h1);
    r0_req_in = 0;
    tick();

    // ---- bounded lock: r0 locked for 6 accesses while r1 waits
    do_reset();
    r0_we_in = 0; r1_we_in = 0;
    r0_req_in = 1; r0_lock_in = 1; r1_req_in = 1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      check($sformatf("lock_c%0d", c),
            {29'b0, mem_re_out, r1_ack_out, r0_ack_out}, {29'b0, t4_exp[c]});
      if (t4_exp[c][2])
        check($sformatf("lock_addr_c%0d", c), mem_addr_out, (c == 10) ? A_SER4 : A_DATA);
      if (c == 11) r1_req_in = 0;
      if (c == 16) begin r0_req_in = 0; r0_lock_in = 0; end
    end

    // ---- asynchronous reset in the middle of an r1 write
    do_reset();
    r1_addr_in = A_STACK; r1_wdata_in = 32'h1234_5678; r1_we_in = 1; r1_size_in = SIZE_WORD;
    ack_base = r1_ack_cnt;
    r1_req_in = 1;
    tick();
    check("rst_busy_we", {31'b0, mem_we_out}, 32'h1);
    #2 reset = 1'b1;
    #1 check("rst_async_clear", {31'b0, any_out()}, 32'h0);
    repeat (2) tick();
    check("rst_held_clear", {31'b0, any_out()}, 32'h0);
    reset = 1'b0;
    check("rst_no_ack", r1_ack_cnt - ack_base, 32'd0);
    tick();
    check("rst_reissue_busy", mem_addr_out, A_STACK);
    tick();
    check("rst_reissue_ack", {30'b0, r1_ack_out, r0_ack_out}, 32'h2);
    r1_req_in = 0;
    tick();

    // ---- serial-segment read by r1
    r1_addr_in = A_SER; r1_we_in = 0;
    we_base = we_cnt; re_base = re_cnt;
    r1_req_in = 1;
    tick();
    check("ser_busy_re",   {31'b0, mem_re_out}, 32'h1);
    check("ser_busy_addr", mem_addr_out, A_SER);
    tick();
    check("ser_ack",       {31'b0, r1_ack_out}, 32'h1);
    check("ser_rdata",     r1_rdata_out, 32'hC0DE_0000);
    check("ser_r0_quiet",  {r0_rdata_out[31:1], r0_ack_out}, 32'h0);
    r1_req_in = 0;
    tick(); tick();
    check("ser_re_pulses", re_cnt - re_base, 32'd1);
    check("ser_we_never",  we_cnt - we_base, 32'd0);
    check("re_we_exclusive", both_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter in front of the `data_memory` request port (addr/writedata/re/we/size/readdata).
- Shares the single port between requester 0 (CPU load/store unit) and requester 1 (serial program loader / debug DMA).
- Uses round-robin arbitration with an optional bounded lock for atomic sequences.
- Each access is registered: one memory cycle, then an acknowledge carrying the read data.

## Interface
Parameters:
- `LOCK_MAX`, default 4: maximum consecutive locked grants to one requester before arbitration is forced.

Ports (clock and reset first):
- `clock` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `r0_req_in` in 1: requester 0 access request, level. Held until `r0_ack_out`.
- `r0_lock_in` in 1: requester 0 wants its next access back-to-back. Sampled in ACK.
- `r0_addr_in` in 32: byte address.
- `r0_wdata_in` in 32: write data.
- `r0_we_in` in 1: 1 = write, 0 = read.
- `r0_size_in` in 2: access size code, passed through unchanged.
- `r0_ack_out` out 1: one-cycle pulse; the access is complete.
- `r0_rdata_out` out 32: registered read data, valid while `r0_ack_out` = 1.
- `r1_*` (all of the above): identical port set for requester 1.
- `mem_addr_out` out 32: to `data_memory` `addr_in`.
- `mem_writedata_out` out 32: to `writedata_in`.
- `mem_re_out` out 1: to `re_in`.
- `mem_we_out` out 1: to `we_in`.
- `mem_size_out` out 2: to `size_in`.
- `mem_readdata_in` in 32: from `readdata_out`. Combinational within the BUSY cycle.

## Operation
States:
- IDLE: arbitrate.
- BUSY: drive the memory port for exactly one cycle.
- ACK: pulse ack and deliver data.

Registers:
- `owner`: 1 bit.
- `last`: 1 bit, the last granted requester.
- `lock_cnt`: clog2(LOCK_MAX+1) bits.
- `rdata`: 32 bits.

IDLE:
- Samples `r0_req_in` / `r1_req_in`. Any high request in IDLE is a new request.
- Only one requester high: grant it.
- Both high: grant `!last` (round-robin).
- On grant: `owner` ← winner, `lock_cnt` ← 1, then go to BUSY.
- No request: stay in IDLE.

BUSY:
- Memory outputs are driven from the owner's inputs.
- `mem_re_out` = ~we and `mem_we_out` = we, for one cycle only.
- At the clock edge: `rdata` ← `mem_readdata_in` for reads; `rdata` ← 0 for writes. `last` ← `owner`. Go to ACK.

ACK:
- The owner's ack is 1 and its rdata output = `rdata`. The other ack stays 0.
- If owner req & owner lock & `lock_cnt` < LOCK_MAX: go to BUSY with the same owner and increment `lock_cnt`. The requester has already presented its next request.
- Otherwise go to IDLE.

Requester rules:
- Must deassert req the cycle after ack unless a new access is intended.
- Address, data, we and size must be held stable from req assertion through ack.

Outside BUSY:
- All `mem_*` outputs = 0; `re` and `we` are never high together.
- The non-owner's ack and rdata outputs are 0.

Lock exhaustion:
- When `lock_cnt` = LOCK_MAX, ACK → IDLE regardless of lock.
- Because `last` = owner, a waiting other requester wins next.

## Timing
Reset values:
- State IDLE, `owner` 0, `last` 1 (so requester 0 wins the first tie), `lock_cnt` 0, `rdata` 0.
- All outputs 0.

Latency and throughput:
- Req seen in IDLE at edge N; BUSY during cycle N+1; ack high during cycle N+2.
- Unlocked: 3 cycles per access.
- Locked: 2 cycles per access (BUSY, ACK alternating).

Writes:
- `data_memory` commits the write on the clock edge that ends BUSY.

Reset mid-operation:
- Any pending access is dropped and no ack is issued.
- A write in BUSY is not guaranteed to commit.
- Requesters re-issue after reset deasserts.

Requests changing mid-access:
- Dropping req in BUSY does not cancel the access; ack is still issued.
- Raising the other req during BUSY or ACK is served next: IDLE arbitration, or immediately after lock exhaustion.

## Structure
Shared package `mem_arb_pkg`:
- State encoding: IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2.
- Size codes: byte = 0, half = 1, word = 2. These must match `data_memory`.
- Address segment constants: 16'h1000, 16'h7fff, 16'hffff.

Sub-module:
- `rr_select`: a 2-input round-robin picker. Inputs: two reqs and `last`. Outputs: grant valid and winner.
- Everything else stays flat in `data_mem_arbiter`.

## Test plan
1. Reset: hold `reset` 3 cycles, then check all outputs are 0. Assert reset asynchronously mid-cycle and check outputs clear immediately.
2. Single write then read: r0 writes 0xDEADBEEF to 0x1000_0010 (size 2). Check ack at N+2 and `mem_we_out` high exactly one cycle. Then r0 reads the same address: `r0_rdata_out` = 0xDEADBEEF at ack.
3. Tie: both reqs rise in the same cycle after reset. Check r0 is served first, r1 second with no idle BUSY gap beyond IDLE. Repeat the tie: r1 is served first this time.
4. Lock with LOCK_MAX = 4: r0 holds lock and req for 6 accesses while r1 is requesting. Check r0 gets 4 consecutive 2-cycle accesses, then r1 is served, then r0 resumes.
5. Reset mid-BUSY during an r1 write to 0x7fff_fffc: check no ack, and `mem_*` outputs are 0 during reset. After release, an r1 re-request completes normally.
6. Serial path: r1 reads 0xffff_0000. Check `mem_re_out` pulses once and `r1_rdata_out` equals `mem_readdata_in` sampled in BUSY. Check `mem_we_out` never rises.
